// File: rtl/typedef_nibble_packer.sv
// typedef_nibble_packer: packs low-first 4-bit nibbles into framed bytes (in_valid/in_ready/in_data/in_last -> out_valid/out_ready/out_data/out_last/out_odd/out_idx, sticky err_overlong)
module typedef_nibble_packer #(
  parameter int FRAME_MAX = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_odd,
  output logic [IDX_W-1:0] out_idx,
  output logic             err_overlong
);
  typedef enum logic [1:0] {ST_LO = 2'd0, ST_HI = 2'd1} st_e;
  typedef struct packed {
    logic [7:0]       data;
    logic             last;
    logic             odd;
    logic [IDX_W-1:0] idx;
  } beat_t;
  st_e state_q, state_d;
  logic [3:0] lo_q, lo_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  beat_t beat_q, beat_d, beat_n;
  logic valid_q, valid_d, err_q, err_d;
  logic accept, produce, cut;
  assign in_ready = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data = beat_q.data;
  assign out_last = beat_q.last;
  assign out_odd = beat_q.odd;
  assign out_idx = beat_q.idx;
  assign err_overlong = err_q;
  always_comb begin
    accept = in_valid && in_ready;
    produce = accept && (state_q == ST_HI || in_last);
    cut = produce && !in_last && idx_q == IDX_W'(FRAME_MAX - 1);
    beat_n = '{data: state_q == ST_HI ? {in_data, lo_q} : {4'h0, in_data},
               last: in_last || cut,
               odd: state_q != ST_HI,
               idx: idx_q};
    state_d = accept ? (state_q == ST_LO && !in_last ? ST_HI : ST_LO) : state_q;
    lo_d = accept && state_q == ST_LO && !in_last ? in_data : lo_q;
    idx_d = produce ? (beat_n.last ? '0 : idx_q + 1'b1) : idx_q;
    beat_d = produce ? beat_n : beat_q;
    valid_d = produce || (valid_q && !out_ready);
    err_d = err_q || cut;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LO;
      lo_q <= '0;
      idx_q <= '0;
      beat_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      idx_q <= idx_d;
      beat_q <= beat_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (state_q == ST_LO || state_q == ST_HI);
      assert (!beat_q.odd || beat_q.last);
      assert (!beat_q.odd || beat_q.data[7:4] == 4'h0);
      assert (!valid_q || 32'(beat_q.idx) < FRAME_MAX);
    end
  end
endmodule

// File: tb/tb_typedef_nibble_packer.sv
// tb_typedef_nibble_packer: directed self-checking bench for typedef_nibble_packer
module tb_typedef_nibble_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [7:0] out_data;
  logic out_last;
  logic out_odd;
  logic [3:0] out_idx;
  logic err_overlong;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic        o;
    logic [3:0]  i;
    logic        e;
    logic [31:0] c;
  } rec_t;
  rec_t mon[$];
  typedef_nibble_packer #(.FRAME_MAX(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_odd(out_odd), .out_idx(out_idx), .err_overlong(err_overlong)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      mon.push_back('{d: out_data, l: out_last, o: out_odd, i: out_idx, e: err_overlong, c: cyc});
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] d, input logic l);
    bit ok = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_odd", out_odd, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_err", err_overlong, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    send(4'h5, 1'b0);
    send(4'hA, 1'b1);
    chk("a5_valid", out_valid, 1);
    chk("a5_data", out_data, 8'hA5);
    chk("a5_last", out_last, 1);
    chk("a5_odd", out_odd, 0);
    chk("a5_idx", out_idx, 0);
    send(4'h7, 1'b1);
    chk("07_data", out_data, 8'h07);
    chk("07_odd", out_odd, 1);
    chk("07_last", out_last, 1);
    chk("07_idx", out_idx, 0);
    send(4'h1, 1'b0);
    send(4'h2, 1'b1);
    chk("21_data", out_data, 8'h21);
    chk("21_idx", out_idx, 0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(4'hC, 1'b0);
    send(4'h3, 1'b0);
    chk("3c_data", out_data, 8'h3C);
    chk("3c_last", out_last, 0);
    in_valid = 1'b1;
    in_data = 4'h6;
    in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h3C);
      chk("stall_idx", out_idx, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("nobubble_valid", out_valid, 1);
    chk("nobubble_data", out_data, 8'h06);
    chk("nobubble_idx", out_idx, 1);
    chk("nobubble_last", out_last, 1);
    @(posedge clk);
    #1 chk("drain_valid", out_valid, 0);
    mon.delete();
    for (int k = 0; k < 34; k++) send(4'(k % 16), 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("long_count", mon.size(), 17);
    for (int k = 0; k < 17 && k < mon.size(); k++) begin
      chk($sformatf("long_data%0d", k), mon[k].d, {4'((2 * k + 1) % 16), 4'((2 * k) % 16)});
      chk($sformatf("long_idx%0d", k), mon[k].i, k % 16);
      chk($sformatf("long_last%0d", k), mon[k].l, k == 15);
      chk($sformatf("long_err%0d", k), mon[k].e, k >= 15);
    end
    chk("long_err_end", err_overlong, 1);
    send(4'h3, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_err", err_overlong, 0);
    chk("arst_data", out_data, 0);
    chk("arst_idx", out_idx, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    send(4'h1, 1'b0);
    send(4'h2, 1'b1);
    chk("post_rst_data", out_data, 8'h21);
    chk("post_rst_odd", out_odd, 0);
    @(posedge clk);
    #1 mon.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i);
      in_last = (i % 4) == 3;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("stream_count", mon.size(), 8);
    for (int k = 0; k < 8 && k < mon.size(); k++) begin
      chk($sformatf("stream_data%0d", k), mon[k].d, {4'(2 * k + 1), 4'(2 * k)});
      chk($sformatf("stream_idx%0d", k), mon[k].i, k % 2);
      chk($sformatf("stream_last%0d", k), mon[k].l, k % 2);
      if (k > 0) chk($sformatf("stream_gap%0d", k), mon[k].c - mon[k - 1].c, 2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/typedef_nibble_packer.md
Name: typedef_nibble_packer

Overview:
- Sequential nibble-to-byte packer for the SV frontend regression suite. It exercises typedef'd enum, packed-struct and scalar types inside clocked logic.
- Upstream, it consumes a stream of 4-bit values, low nibble first. Downstream, it emits 8-bit bytes with framing metadata.
- Self-checking through immediate assertions on its own outputs, so it runs under sim and formal flows.

Parameters:
- FRAME_MAX, 16: maximum bytes per frame before a forced frame end. Legal range 2..16.
- IDX_W, 4: width of the byte-index counter. Must satisfy 2**IDX_W >= FRAME_MAX.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream nibble valid.
- in_ready  output  1  upstream ready.
- in_data  input  4  nibble.
- in_last  input  1  nibble is the final one of its frame.
- out_valid  output  1  byte valid.
- out_ready  input  1  downstream ready.
- out_data  output  8  assembled byte.
- out_last  output  1  byte ends its frame.
- out_odd  output  1  byte built from a single nibble; high nibble is zero-padded.
- out_idx  output  IDX_W  byte index within the frame.
- err_overlong  output  1  sticky flag: a frame was forcibly cut at FRAME_MAX.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, out_data, out_last, out_odd, out_idx, err_overlong all 0.
  - Pack state ST_LO; held low nibble 0.
  - A partially assembled byte is discarded.
- Handshakes:
  - in_ready = !out_valid || out_ready, combinational and in every state.
  - An input beat transfers on in_valid && in_ready.
  - An output beat transfers on out_valid && out_ready.
  - out_data, out_last, out_odd and out_idx hold stable while out_valid && !out_ready.
- Pack FSM, 2-bit enum {ST_LO=0, ST_HI=1}. State 2'b10/2'b11 is unreachable; it is asserted never to occur.
  - ST_LO, accept, in_last=0: latch nibble into lo_q; go to ST_HI; no byte produced.
  - ST_LO, accept, in_last=1: produce byte {4'h0, in_data} with out_odd=1 and out_last=1; stay in ST_LO.
  - ST_HI, accept: produce byte {in_data, lo_q} with out_odd=0 and out_last=in_last; go to ST_LO.
- Produce:
  - The output register loads on the accepting edge, so out_valid rises the following cycle (1-cycle latency).
  - A produce in the same cycle as an output transfer replaces the register with no bubble; out_valid stays 1.
  - If the register drains with no produce, out_valid falls.
- Peak throughput: one byte per two input beats.
- Index:
  - idx_q is the index assigned to the next produced byte; out_idx is the value captured with each byte.
  - On a produce with final out_last=1, idx_q returns to 0; otherwise idx_q increments.
- Overlong frame:
  - When a byte is produced with idx_q == FRAME_MAX-1 and in_last=0, force out_last=1, set err_overlong, and reset idx_q to 0.
  - err_overlong is cleared only by rst.
  - FSM state is unaffected; a held low nibble cannot exist at a produce point.
- Arithmetic: idx_q is IDX_W wide and never exceeds FRAME_MAX-1. Index compares are unsigned, at IDX_W width.
- In-valid while ST_HI and output stalled: in_ready=0 and the nibble waits; no loss and no duplication.
- Embedded assertions:
  - out_odd implies out_last.
  - out_odd implies out_data[7:4]==0.
  - out_idx < FRAME_MAX whenever out_valid.

Test Plan:
- Reset, then nibbles 5, A (in_last on A), out_ready=1 -> one cycle after A is accepted: out_valid=1, out_data=8'hA5, out_last=1, out_odd=0, out_idx=0.
- In ST_LO, nibble 7 with in_last=1 -> out_data=8'h07, out_odd=1, out_last=1, out_idx=0. The next frame's first byte has out_idx=0.
- Byte 8'h3C pending with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0 throughout, outputs stable. Raise out_ready -> 8'h3C transfers, in_ready=1 that same cycle, and the next byte follows with no bubble.
- FRAME_MAX=16, 34 nibbles 0..F repeating with no in_last:
  - bytes 0..15 carry out_idx 0..15;
  - the byte with out_idx=15 has out_last=1 and err_overlong rises;
  - the 17th byte has out_idx=0;
  - err_overlong stays 1.
- Nibble 3 accepted (ST_HI), then rst pulsed asynchronously mid-cycle -> all outputs 0 immediately. Afterwards nibbles 1, 2 yield 8'h21, not 8'h13.
- Continuous in_valid=1, out_ready=1 with alternating in_last -> one byte every 2 cycles, out_idx alternates 0/1 per frame, and no assertion fires.
